// File: rtl/univ_shift_reg_pkg.sv
// Shared types and the single-step shift helper for the universal shift register.
package usr_pkg;

    // Command opcodes; encoding 3'd7 is unused and is executed as NOP.
    typedef enum logic [2:0] {
        NOP  = 3'd0,
        SHL  = 3'd1,
        SHR  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        ASR  = 3'd5,
        LOAD = 3'd6
    } op_e;

    // Control states: only IDLE accepts commands.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest register the helper function supports.
    localparam int MAX_W = 64;

    // Result of one step: new register value (zero-extended) and the bit that left.
    typedef struct packed {
        logic [MAX_W-1:0] q;
        logic             sout;
    } step_t;

    // One single-bit shift/rotate step on the low 'width' bits of q.
    // Bits above 'width' in the result are always zero. Non-shift ops return q unchanged.
    function automatic step_t shiftStep(input op_e op, input logic [MAX_W-1:0] q,
                                        input int width, input logic din);
        step_t            res;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] dinExt;
        logic             msb;
        logic             lsb;
        mask   = (64'd1 << width) - 64'd1;
        dinExt = {63'd0, din};
        msb    = q[width-1];
        lsb    = q[0];
        res.q    = q;
        res.sout = 1'b0;
        case (op)
            SHL: begin
                res.q    = ((q << 1) | dinExt) & mask;
                res.sout = msb;
            end
            SHR: begin
                res.q    = (q >> 1) | (dinExt << (width - 1));
                res.sout = lsb;
            end
            ROL: begin
                res.q    = ((q << 1) | {63'd0, msb}) & mask;
                res.sout = msb;
            end
            ROR: begin
                res.q    = (q >> 1) | ({63'd0, lsb} << (width - 1));
                res.sout = lsb;
            end
            ASR: begin
                res.q    = (q >> 1) | ({63'd0, msb} << (width - 1));
                res.sout = lsb;
            end
            default: begin
                res.q    = q;
                res.sout = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: LOAD in one edge, shift/rotate ops executed one bit per clock.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             din,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    state_e           w_nextState;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_done;

    op_e              w_op;
    logic             w_accept;
    logic             w_isShift;
    logic             w_lastStep;
    logic [MAX_W-1:0] w_qExt;
    step_t            w_step;
    logic             w_unused;

    assign w_op       = op_e'(op);
    assign w_accept   = start && (r_state == IDLE);
    assign w_isShift  = (w_op == SHL) || (w_op == SHR) || (w_op == ROL) ||
                        (w_op == ROR) || (w_op == ASR);
    assign w_lastStep = (r_cnt == CNT_W'(1));

    // Zero-extend the register so the package helper can work at its fixed width.
    always_comb begin
        w_qExt = '0;
        w_qExt[WIDTH-1:0] = r_q;
    end

    assign w_step   = shiftStep(r_op, w_qExt, WIDTH, din);
    assign w_unused = ^w_step.q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: enter RUN only for a real multi-step command, leave after the last step.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_isShift && (count != '0)) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastStep) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs: busy follows RUN directly, the rest come from datapath registers.
    always_comb begin
        busy = (r_state == RUN);
        done = r_done;
        q    = r_q;
        sout = r_sout;
    end

    // Datapath: command capture in IDLE, one step per edge in RUN, done pulse one cycle after finishing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_done <= 1'b0;
            r_op   <= NOP;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    if (w_op == LOAD) begin
                        r_q    <= pdata;
                        r_done <= 1'b1;
                    end else if (w_isShift && (count != '0)) begin
                        r_op  <= w_op;
                        r_cnt <= count;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else begin
                r_q    <= w_step.q[WIDTH-1:0];
                r_sout <= w_step.sout;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (w_lastStep) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg at WIDTH=8 with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_SHL  = 3'd1;
    localparam logic [2:0] C_SHR  = 3'd2;
    localparam logic [2:0] C_ROL  = 3'd3;
    localparam logic [2:0] C_ROR  = 3'd4;
    localparam logic [2:0] C_ASR  = 3'd5;
    localparam logic [2:0] C_LOAD = 3'd6;
    localparam logic [2:0] C_BAD  = 3'd7;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic             din;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .count   (count),
        .din     (din),
        .pdata   (pdata),
        .q       (q),
        .sout    (sout),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a command now, let one posedge (E0) take it, and return 1 time unit after E0.
    task automatic issue(input logic [2:0] o, input int c, input logic d, input logic [7:0] p);
        start = 1'b1;
        op    = o;
        count = CNT_W'(c);
        din   = d;
        pdata = p;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles with busy high and any cycle with both high.
    task automatic waitDone(output int busyCycles, output int overlap, output bit gotDone);
        busyCycles = 0;
        overlap    = 0;
        gotDone    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done && busy) overlap++;
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({q, sout, busy, done} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got q=%h sout=%b busy=%b done=%b want all zero", q, sout, busy, done);
        end
        // Release reset and present a LOAD immediately: the first posedge must take it.
        reset_n = 1'b1;
        issue(C_LOAD, 0, 1'b0, 8'h3C);
        vectors++;
        if (q !== 8'h3C || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL first_cmd got q=%h done=%b want q=3c done=1", q, done);
        end
        // Assert reset between edges while done is high: everything clears without a clock.
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got q=%h busy=%b done=%b want 00/0/0", q, busy, done);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load;
        int  bc;
        int  ov;
        bit  ok;
        issue(C_LOAD, 0, 1'b0, 8'hA5);
        vectors++;
        if (q !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load got q=%h done=%b busy=%b want a5/1/0", q, done, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_pulse got done=%b busy=%b want 0/0", done, busy);
        end
        // SHL x3 with din=1 from A5: A5 -> 4B -> 97 -> 2F, last bit out is 1.
        issue(C_SHL, 3, 1'b1, 8'h00);
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'h2F || sout !== 1'b1 || bc != 3 || ov != 0) begin
            miscompares++;
            $display("[TB] FAIL shl3 got q=%h sout=%b busy_cycles=%0d done=%b overlap=%0d want 2f/1/3/1/0",
                     q, sout, bc, ok, ov);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL shl3_after got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_rotate;
        int  bc;
        int  ov;
        bit  ok;
        // ROR x4 on 3C, with a LOAD attempt injected while busy that must be ignored.
        issue(C_LOAD, 0, 1'b0, 8'h3C);
        issue(C_ROR, 4, 1'b1, 8'h00);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ror_busy got busy=%b done=%b want 1/0", busy, done);
        end
        issue(C_LOAD, 0, 1'b0, 8'h00);
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'hC3 || sout !== 1'b1 || bc != 3 || ov != 0) begin
            miscompares++;
            $display("[TB] FAIL ror4_ignore_load got q=%h sout=%b busy_after=%0d done=%b want c3/1/3/1",
                     q, sout, bc, ok);
        end
        // LOAD 80 then ASR x2 issued in the LOAD's done cycle: 80 -> C0 -> E0.
        issue(C_LOAD, 0, 1'b0, 8'h80);
        issue(C_ASR, 2, 1'b1, 8'h00);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_to_back got busy=%b want 1", busy);
        end
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'hE0 || sout !== 1'b0 || bc != 2) begin
            miscompares++;
            $display("[TB] FAIL asr2 got q=%h sout=%b busy_cycles=%0d done=%b want e0/0/2/1", q, sout, bc, ok);
        end
        // ROL x9 on 81 wraps once past the width: 81 -> ... -> 81 -> 03.
        issue(C_LOAD, 0, 1'b0, 8'h81);
        issue(C_ROL, 9, 1'b0, 8'h00);
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'h03 || sout !== 1'b1 || bc != 9 || ov != 0) begin
            miscompares++;
            $display("[TB] FAIL rol9 got q=%h sout=%b busy_cycles=%0d done=%b want 03/1/9/1", q, sout, bc, ok);
        end
    endtask

    task automatic test_boundaries;
        int  bc;
        int  ov;
        bit  ok;
        // SHR with count 0 completes immediately without touching q.
        issue(C_SHR, 0, 1'b1, 8'h00);
        vectors++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL shr0 got q=%h done=%b busy=%b want 03/1/0", q, done, busy);
        end
        // Undefined opcode behaves as NOP.
        issue(C_BAD, 5, 1'b1, 8'hFF);
        vectors++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_op got q=%h done=%b busy=%b want 03/1/0", q, done, busy);
        end
        issue(C_NOP, 2, 1'b0, 8'h00);
        vectors++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nop got q=%h done=%b busy=%b want 03/1/0", q, done, busy);
        end
        // SHL x10 with din=1: every bit is replaced by din, last bit out is a filled 1.
        issue(C_SHL, 10, 1'b1, 8'h00);
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'hFF || sout !== 1'b1 || bc != 10) begin
            miscompares++;
            $display("[TB] FAIL shl10 got q=%h sout=%b busy_cycles=%0d done=%b want ff/1/10/1", q, sout, bc, ok);
        end
        // SHR x2 with din=0 from FF: FF -> 7F -> 3F, bit out is 1.
        issue(C_SHR, 2, 1'b0, 8'h00);
        waitDone(bc, ov, ok);
        vectors++;
        if (!ok || q !== 8'h3F || sout !== 1'b1 || bc != 2) begin
            miscompares++;
            $display("[TB] FAIL shr2 got q=%h sout=%b busy_cycles=%0d done=%b want 3f/1/2/1", q, sout, bc, ok);
        end
    endtask

    task automatic test_abort;
        int  seenDone;
        seenDone = 0;
        issue(C_LOAD, 0, 1'b0, 8'h0F);
        issue(C_SHL, 5, 1'b1, 8'h00);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_reset got q=%h busy=%b done=%b sout=%b want 00/0/0/0", q, busy, done, sout);
        end
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seenDone++;
        end
        vectors++;
        if (seenDone != 0 || q !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL abort_idle got stray_cycles=%0d q=%h want 0/00", seenDone, q);
        end
        issue(C_LOAD, 0, 1'b0, 8'h5A);
        vectors++;
        if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_after_abort got q=%h done=%b busy=%b want 5a/1/0", q, done, busy);
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        op          = C_NOP;
        count       = '0;
        din         = 1'b0;
        pdata       = '0;
        test_reset;
        test_load;
        test_rotate;
        test_boundaries;
        test_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the count input.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  command request, sampled on posedge clk.
REQ-006 op  in  3  command opcode (op_e): NOP, SHL, SHR, ROL, ROR, ASR, LOAD.
REQ-007 count  in  CNT_W  number of single-bit shift steps for shift/rotate ops.
REQ-008 din  in  1  serial input bit, sampled on every SHL/SHR step.
REQ-009 pdata  in  WIDTH  parallel load data for LOAD.
REQ-010 q  out  WIDTH  register contents.
REQ-011 sout  out  1  bit shifted or rotated out on the most recent step.
REQ-012 busy  out  1  high while a multi-step command executes.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, RUN; only IDLE accepts commands.
REQ-015 Accept edge E0: start=1 and state IDLE; op, count, and pdata are sampled at E0.
REQ-016 start while busy=1 is ignored; no queuing, no effect on the running command.
REQ-017 LOAD: q<=pdata at E0; state stays IDLE; sout unchanged; done=1 for the cycle after E0.
REQ-018 NOP, or any shift/rotate op with count=0: q unchanged; done=1 for the cycle after E0; busy stays 0.
REQ-019 Shift/rotate op with count=N>0: at E0, latch op, load step counter=N, enter RUN; busy=1 from the cycle after E0.
REQ-020 In RUN, perform exactly one step per edge E1..EN; at EN, return to IDLE; busy=0 and done=1 for the cycle after EN.
REQ-021 SHL step: q<={q[WIDTH-2:0],din}; sout<=old q[WIDTH-1].
REQ-022 SHR step: q<={din,q[WIDTH-1:1]}; sout<=old q[0].
REQ-023 ROL step: q<={q[WIDTH-2:0],q[WIDTH-1]}; sout<=old q[WIDTH-1]; din ignored.
REQ-024 ROR step: q<={q[0],q[WIDTH-1:1]}; sout<=old q[0]; din ignored.
REQ-025 ASR step: q<={q[WIDTH-1],q[WIDTH-1:1]}; sout<=old q[0]; din ignored.
REQ-026 count>WIDTH is executed literally with no clamping: rotates wrap, and logical shifts fill entirely from din.
REQ-027 Undefined op encodings behave as NOP.
REQ-028 done and busy are never high in the same cycle; a new start is accepted in the same cycle done=1.

Reset
REQ-029 reset_n=0 immediately forces q=0, sout=0, busy=0, done=0, state=IDLE, and step counter=0, regardless of clk.
REQ-030 Reset asserted mid-RUN aborts the command; no done pulse is issued for it.
REQ-031 The first command is accepted at the first posedge clk after reset_n deasserts.

Structure
REQ-032 Package usr_pkg holds op_e (3-bit enum), state_e (IDLE/RUN), and a pure function implementing one shift step for a given op.
REQ-033 Single module; no sub-module; WIDTH and CNT_W are the only parameters.

Verification (WIDTH=8)
REQ-034 Reset: reset_n low mid-cycle -> q=0x00, busy=0, done=0 without waiting for a clock edge.
REQ-035 LOAD: pdata=0xA5 -> q=0xA5 after E0; done high one cycle; busy never high.
REQ-036 SHL: from q=0xA5, count=3, din=1 -> q=0x2F after E3; sout=1; busy high 3 cycles; done in the cycle after E3.
REQ-037 Rotate/arithmetic: ROR count=4 on 0x3C -> 0xC3; ASR count=2 on 0x80 -> 0xE0; ROL count=9 on 0x81 -> 0x03.
REQ-038 Boundaries: SHR count=0 -> q unchanged and done the next cycle; start with LOAD during RUN -> ignored; back-to-back start in the done cycle -> accepted.
REQ-039 Abort: reset_n pulsed low during RUN of SHL count=5 -> q=0, IDLE, no done pulse; a following LOAD 0x5A completes normally.
